// File: rtl/div_issue_ctrl.sv
// Issue controller for a fixed-latency pipelined divider shared by two requesters.
// Handles round-robin arbitration, credit-based issue against a result FIFO,
// completion tracking via an internal valid shift register, and CDB broadcast.
module div_issue_ctrl #(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req0_pc,
  input  logic [7:0]  req0_tag,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [31:0] req1_pc,
  input  logic [7:0]  req1_tag,
  input  logic [3:0]  req1_op,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic [31:0] div_pc,
  output logic [7:0]  div_tag,
  output logic [3:0]  div_op,
  input  logic [31:0] div_result,
  input  logic [7:0]  div_tag_in,
  input  logic [31:0] div_pc_in,
  output logic        cdb_valid,
  input  logic        cdb_ready,
  output logic [31:0] cdb_result,
  output logic [31:0] cdb_pc,
  output logic [7:0]  cdb_tag,
  output logic        busy,
  output logic [4:0]  outstanding
);

  localparam int PW = $clog2(DEPTH);

  logic               ptr;
  logic               credit;
  logic               grant0;
  logic               grant1;
  logic               accept;
  logic               sel1;
  logic               capture;
  logic               pop;
  logic [LATENCY-1:0] vld_pipe;
  logic [31:0]        last_a;
  logic [31:0]        last_b;
  logic [31:0]        last_pc;
  logic [7:0]         last_tag;
  logic [3:0]         last_op;
  logic [31:0]        res_mem [DEPTH];
  logic [7:0]         tag_mem [DEPTH];
  logic [31:0]        pc_mem  [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW:0]        fcount;

  // Credit check plus round-robin grant; ready goes only to the winner.
  always_comb begin
    credit     = !reset && !flush && (outstanding < 5'(DEPTH));
    grant0     = req0_valid && (!req1_valid || !ptr);
    grant1     = req1_valid && (!req0_valid || ptr);
    req0_ready = credit && grant0;
    req1_ready = credit && grant1;
    accept     = req0_ready || req1_ready;
    sel1       = req1_ready;
  end

  // Issue mux: winner's operands on accept, otherwise the last issued values.
  always_comb begin
    div_start = accept;
    div_a     = last_a;
    div_b     = last_b;
    div_pc    = last_pc;
    div_tag   = last_tag;
    div_op    = last_op;
    if (accept) begin
      if (sel1) begin
        div_a   = req1_a;
        div_b   = req1_b;
        div_pc  = req1_pc;
        div_tag = req1_tag;
        div_op  = req1_op;
      end else begin
        div_a   = req0_a;
        div_b   = req0_b;
        div_pc  = req0_pc;
        div_tag = req0_tag;
        div_op  = req0_op;
      end
    end
  end

  // Remember issued operands and hand priority to the requester that lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= 1'b0;
      last_a   <= '0;
      last_b   <= '0;
      last_pc  <= '0;
      last_tag <= '0;
      last_op  <= '0;
    end else if (accept) begin
      ptr      <= !sel1;
      last_a   <= div_a;
      last_b   <= div_b;
      last_pc  <= div_pc;
      last_tag <= div_tag;
      last_op  <= div_op;
    end
  end

  // Completion tracker: the divider's own capture persists without a start,
  // so a result is only trusted when this accept-fed shift register says so.
  always_ff @(posedge clk) begin
    if (reset || flush) vld_pipe <= '0;
    else                vld_pipe <= {vld_pipe[LATENCY-2:0], accept};
  end

  assign capture   = vld_pipe[LATENCY-1];
  assign cdb_valid = (fcount != '0);
  assign pop       = cdb_valid && cdb_ready;

  // Result FIFO pointers and occupancy; capture and pop may coincide.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      unique case ({capture, pop})
        2'b10:   fcount <= fcount + (PW+1)'(1);
        2'b01:   fcount <= fcount - (PW+1)'(1);
        default: fcount <= fcount;
      endcase
    end
  end

  // Result FIFO storage; cleared on reset so the CDB data reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_mem[i] <= '0;
        tag_mem[i] <= '0;
        pc_mem[i]  <= '0;
      end
    end else if (capture && !flush) begin
      res_mem[wr_ptr] <= div_result;
      tag_mem[wr_ptr] <= div_tag_in;
      pc_mem[wr_ptr]  <= div_pc_in;
    end
  end

  assign cdb_result = res_mem[rd_ptr];
  assign cdb_tag    = tag_mem[rd_ptr];
  assign cdb_pc     = pc_mem[rd_ptr];

  // Credit counter covering both in-flight and queued ops.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      outstanding <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   outstanding <= outstanding + 5'd1;
        2'b01:   outstanding <= outstanding - 5'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign busy = (outstanding != 5'd0);

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, 8, result-FIFO entries and maximum outstanding ops (power of 2, 2..16).
REQ-002 SHALL have parameter LATENCY, 32, clk edges from a divider start sample to its registered result.
REQ-003 clk  in  1  clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 flush  in  1  kill all queued and in-flight ops (branch mispredict).
REQ-006 reqN_valid / reqN_ready  in/out  1/1  per-requester handshake, N=0,1.
REQ-007 reqN_a, reqN_b, reqN_pc  in  32 each  dividend, divisor, PC.
REQ-008 reqN_tag  in  8  physical destination register; reqN_op  in  4  0001=quotient, other=remainder.
REQ-009 div_start  out  1  issue strobe to pipelined divider; div_a, div_b, div_pc (32), div_tag (8), div_op (4)  out  issued operands.
REQ-010 div_result  in  32  divider Result; div_tag_in  in  8; div_pc_in  in  32.
REQ-011 cdb_valid  out  1; cdb_ready  in  1; cdb_result, cdb_pc  out  32; cdb_tag  out  8  broadcast port.
REQ-012 busy  out  1  any op in flight or queued; outstanding  out  5  in-flight + queued count.

Function
REQ-013 Credit rule: issue allowed only when outstanding < DEPTH and flush=0.
REQ-014 Round-robin arbiter: pointer ptr (reset 0) names the priority requester; if both valid, ptr wins, else the sole valid one wins.
REQ-015 reqN_ready SHALL be combinational: 1 only for the winner, only when the credit rule holds; at most one ready per cycle.
REQ-016 Accept = reqN_valid & reqN_ready; on accept ptr SHALL become the non-granted index; otherwise ptr holds.
REQ-017 On accept, div_start=1 in the same cycle with div_* driven from the winner; otherwise div_start=0, div_* hold last value.
REQ-018 Divider capture is not trusted for completion (its done/stage-0 contents persist without start); completion SHALL come from an internal LATENCY-deep valid shift register fed by accept.
REQ-019 When the shift-register tail is 1, {div_result, div_tag_in, div_pc_in} SHALL be written into the FIFO that cycle.
REQ-020 FIFO: DEPTH entries, circular read/write pointers wrap at DEPTH; cdb_valid = not empty; cdb_* = head entry; pop on cdb_valid & cdb_ready.
REQ-021 Simultaneous capture and pop SHALL both occur; count unchanged; empty FIFO with capture SHALL show cdb_valid next cycle (no bypass).
REQ-022 outstanding SHALL be +1 on accept, -1 on pop, unchanged when both; never exceeds DEPTH, so FIFO cannot overflow.
REQ-023 Accept-to-cdb_valid latency with empty FIFO and cdb_ready=1: LATENCY+1 cycles (33 by default).
REQ-024 flush=1: next cycle shift register, FIFO pointers, outstanding cleared; cdb_valid=0; no accept that cycle; killed ops never reach the CDB; ptr holds.
REQ-025 Divide-by-zero SHALL be issued unchanged; the controller neither detects nor alters it.
REQ-026 busy = (outstanding != 0).

Reset
REQ-027 On reset: ptr=0, shift register all 0, FIFO empty, outstanding=0, cdb_valid=0, div_start=0, div_* and cdb_* data =0, busy=0.
REQ-028 Reset during in-flight ops SHALL discard them; no cdb_valid until new accepts complete.
REQ-029 Reset overrides flush and requests in the same cycle.

Verification
REQ-030 Single op: req0 A=100,B=7,op=0001,tag=0x12 accepted at cycle 0 -> cdb_valid at cycle 33 with result 14, tag 0x12; op=0000 -> result 2.
REQ-031 Both requesters valid every cycle after reset -> grants 0,1,0,1...; each tag appears on CDB exactly once, in issue order.
REQ-032 cdb_ready=0, 10 requests offered -> exactly 8 accepted, ready low after, outstanding=8; raise cdb_ready -> 8 results drain, accepting resumes.
REQ-033 4 ops issued, flush at cycle 10 -> no cdb_valid from them, outstanding=0 at cycle 11; op issued at cycle 12 returns at cycle 45.
REQ-034 Capture and pop in same cycle with FIFO at 3 -> count stays 3, pointers wrap correctly past DEPTH-1.
REQ-035 A=5,B=0,op=0001 -> CDB result 0xFFFFFFFF; op=0000 -> result 5.
